// File: rtl/adc_scan_ctrl.sv
// Round-robin channel scanner for an ADC0809-class converter: sequences ADDR/ALE/START/OE,
// keeps raw and scaled readings per channel. Define ADC_SCAN_AVG_EN for per-channel averaging.
module adc_scan_ctrl #(
    parameter int NUM_CH      = 8,
    parameter int CLK_DIV     = 40,
    parameter int PHASE_CYC   = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int FULL_SCALE  = 1000,
    parameter int SW          = 10,
    parameter int AVG_LOG2    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              eoc,
    input  logic [7:0]        result,
    output logic              start,
    output logic              ale,
    output logic              out_en,
    output logic              adc_clk,
    output logic [2:0]        addr,
    input  logic [2:0]        rd_ch,
    output logic [7:0]        rd_raw,
    output logic [SW-1:0]     rd_scaled,
    output logic [NUM_CH-1:0] ch_valid,
    output logic              scan_done,
    output logic              timeout_err,
    output logic [7:0]        led
);

    localparam int CW  = (NUM_CH > 1)      ? $clog2(NUM_CH)      : 1;
    localparam int PCW = (PHASE_CYC > 1)   ? $clog2(PHASE_CYC)   : 1;
    localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int DW  = (CLK_DIV > 1)     ? $clog2(CLK_DIV)     : 1;
    localparam int PW  = 8 + SW;

    localparam logic [CW-1:0]  LAST_CH    = CW'(NUM_CH - 1);
    localparam logic [PCW-1:0] PHASE_LAST = PCW'(PHASE_CYC - 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [DW-1:0]  DIV_LAST   = DW'(CLK_DIV - 1);

    if (NUM_CH < 1 || NUM_CH > 8 || CLK_DIV < 1 || PHASE_CYC < 1 || TIMEOUT_CYC < 1 ||
        FULL_SCALE >= (1 << SW) || AVG_LOG2 < 0 || AVG_LOG2 > 8) begin : g_param_check
        $error("adc_scan_ctrl: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LATCH, S_WAIT_LO, S_WAIT_HI, S_READ, S_STORE
    } state_e;

    state_e          state_q;
    logic [PCW-1:0]  phase_q;
    logic [TW-1:0]   timer_q;
    logic [CW-1:0]   ch_q;
    logic [2:0]      addr_q;
    logic            start_q, ale_q, out_en_q;
    logic [7:0]      data_q;
    logic [7:0]      raw_q [NUM_CH];
    logic [NUM_CH-1:0] valid_q;
    logic            scan_done_q, timeout_q;
    logic [7:0]      led_q;
    logic            eoc_meta_q, eoc_sync_q;
    logic [DW-1:0]   div_q;
    logic            adc_clk_q;

    logic [CW-1:0]   ch_next_d;
    logic            wrap_d;
    logic [7:0]      store_val_d;
    logic [PW-1:0]   scaled_prod;

`ifdef ADC_SCAN_AVG_EN
    localparam int AW   = 8 + AVG_LOG2;
    localparam int SMPW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [SMPW-1:0] SMP_LAST = SMPW'((1 << AVG_LOG2) - 1);

    logic [AW-1:0]   acc_q, sum_d;
    logic [SMPW-1:0] smp_q;
    logic            last_smp_d;
`endif

    // eoc is asynchronous to clk; only eoc_sync_q is used by the sequencer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eoc_meta_q <= 1'b0;
            eoc_sync_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so both flops sample the old values, forming a real 2-stage chain.
            eoc_meta_q <= eoc;
            eoc_sync_q <= eoc_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q     <= '0;
            adc_clk_q <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q     <= '0;
            adc_clk_q <= ~adc_clk_q;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        ch_next_d = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
        wrap_d    = (ch_q == LAST_CH);
`ifdef ADC_SCAN_AVG_EN
        sum_d       = acc_q + AW'(data_q);
        last_smp_d  = (smp_q == SMP_LAST);
        store_val_d = 8'(sum_d >> AVG_LOG2);
`else
        store_val_d = data_q;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            timer_q     <= '0;
            ch_q        <= '0;
            addr_q      <= '0;
            start_q     <= 1'b0;
            ale_q       <= 1'b0;
            out_en_q    <= 1'b0;
            data_q      <= '0;
            valid_q     <= '0;
            scan_done_q <= 1'b0;
            timeout_q   <= 1'b0;
            led_q       <= '0;
            // NOTE: the channel store is a handful of flops that must read 0 after reset, so it is reset.
            for (int i = 0; i < NUM_CH; i++) raw_q[i] <= '0;
`ifdef ADC_SCAN_AVG_EN
            acc_q <= '0;
            smp_q <= '0;
`endif
        end else begin
            scan_done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_ADDR;
                        addr_q  <= 3'(ch_q);
                        phase_q <= '0;
                    end
                end
                S_ADDR: begin
                    if (phase_q == PHASE_LAST) begin
                        phase_q <= '0;
                        ale_q   <= 1'b1;
                        start_q <= 1'b1;
                        state_q <= S_LATCH;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                S_LATCH: begin
                    if (phase_q == PHASE_LAST) begin
                        phase_q <= '0;
                        ale_q   <= 1'b0;
                        start_q <= 1'b0;
                        timer_q <= '0;
                        state_q <= S_WAIT_LO;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                S_WAIT_LO, S_WAIT_HI: begin
                    if (timer_q != TIMER_LAST) timer_q <= timer_q + 1'b1;
                    if (state_q == S_WAIT_LO && !eoc_sync_q) begin
                        state_q <= S_WAIT_HI;
                    end else if (state_q == S_WAIT_HI && eoc_sync_q) begin
                        state_q  <= S_READ;
                        out_en_q <= 1'b1;
                        phase_q  <= '0;
                    end else if (timer_q == TIMER_LAST) begin
                        // Converter never answered: flag it, drop this channel's reading, move on.
                        timeout_q      <= 1'b1;
                        valid_q[ch_q]  <= 1'b0;
                        ch_q           <= ch_next_d;
                        scan_done_q    <= wrap_d;
                        addr_q         <= 3'(ch_next_d);
                        phase_q        <= '0;
                        state_q        <= enable ? S_ADDR : S_IDLE;
`ifdef ADC_SCAN_AVG_EN
                        acc_q <= '0;
                        smp_q <= '0;
`endif
                    end
                end
                S_READ: begin
                    if (phase_q == PHASE_LAST) begin
                        data_q   <= result;
                        out_en_q <= 1'b0;
                        phase_q  <= '0;
                        state_q  <= S_STORE;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                S_STORE: begin
                    phase_q <= '0;
                    state_q <= enable ? S_ADDR : S_IDLE;
`ifdef ADC_SCAN_AVG_EN
                    if (!last_smp_d) begin
                        acc_q  <= sum_d;
                        smp_q  <= smp_q + 1'b1;
                        addr_q <= 3'(ch_q);
                    end else begin
                        acc_q <= '0;
                        smp_q <= '0;
`endif
                        raw_q[ch_q]   <= store_val_d;
                        valid_q[ch_q] <= 1'b1;
                        led_q         <= store_val_d;
                        ch_q          <= ch_next_d;
                        scan_done_q   <= wrap_d;
                        addr_q        <= 3'(ch_next_d);
`ifdef ADC_SCAN_AVG_EN
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_raw = '0;
        if (int'(rd_ch) < NUM_CH) rd_raw = raw_q[rd_ch[CW-1:0]];
        scaled_prod = PW'(rd_raw) * PW'(FULL_SCALE);
        rd_scaled   = SW'(scaled_prod / PW'(255));
    end

    assign start       = start_q;
    assign ale         = ale_q;
    assign out_en      = out_en_q;
    assign adc_clk     = adc_clk_q;
    assign addr        = addr_q;
    assign ch_valid    = valid_q;
    assign scan_done   = scan_done_q;
    assign timeout_err = timeout_q;
    assign led         = led_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench for adc_scan_ctrl: a behavioural ADC answers each START with random data,
// expected stores are queued and checked by an independent monitor when OE completes.
module tb_adc_scan_ctrl;

    localparam int NUM_CH      = 4;
    localparam int CLK_DIV     = 3;
    localparam int PHASE_CYC   = 2;
    localparam int TIMEOUT_CYC = 300;
    localparam int FULL_SCALE  = 1000;
    localparam int SW          = 10;
    localparam int AVG_LOG2    = 2;
`ifdef ADC_SCAN_AVG_EN
    localparam int AVG_N = 1 << AVG_LOG2;
`else
    localparam int AVG_N = 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              eoc;
    logic [7:0]        result;
    logic              start, ale, out_en, adc_clk;
    logic [2:0]        addr;
    logic [2:0]        rd_ch;
    logic [7:0]        rd_raw;
    logic [SW-1:0]     rd_scaled;
    logic [NUM_CH-1:0] ch_valid;
    logic              scan_done, timeout_err;
    logic [7:0]        led;

    adc_scan_ctrl #(
        .NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .PHASE_CYC(PHASE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC),
        .FULL_SCALE(FULL_SCALE), .SW(SW), .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .eoc(eoc), .result(result),
        .start(start), .ale(ale), .out_en(out_en), .adc_clk(adc_clk), .addr(addr),
        .rd_ch(rd_ch), .rd_raw(rd_raw), .rd_scaled(rd_scaled), .ch_valid(ch_valid),
        .scan_done(scan_done), .timeout_err(timeout_err), .led(led)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        bit fin;
        int val;
    } rec_t;

    rec_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bit model_on     = 0;
    bit hang_arm     = 0;
    bit drop_arm     = 0;
    bit timeout_seen = 0;
    int exp_ch       = 0;
    int smp_idx      = 0;
    int exp_wraps    = 0;
    int n_starts     = 0;
    int sd_cnt       = 0;
    int acc      [NUM_CH];
    int stored   [NUM_CH];
    int pass_cnt [NUM_CH];
    bit exp_valid[NUM_CH];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int scaled_of(input int raw);
        return raw * FULL_SCALE / 255;
    endfunction

    // First two passes use fixed readings on ch0/ch1 so known scaled values can be read back.
    function automatic int pick_value(input int ch, input int pass, input int smp);
        int avg_tab[4];
        avg_tab = '{10, 20, 30, 41};
        if (pass < 2 && ch == 0) return (AVG_N == 4) ? avg_tab[smp] : 255;
        if (pass < 2 && ch == 1) return 128;
        return int'($urandom_range(0, 255));
    endfunction

    task automatic check_reset_state(input string tag);
        rd_ch = 3'd0;
        #1;
        check({tag, "_start"},       start, 0);
        check({tag, "_ale"},         ale, 0);
        check({tag, "_out_en"},      out_en, 0);
        check({tag, "_adc_clk"},     adc_clk, 0);
        check({tag, "_addr"},        addr, 0);
        check({tag, "_led"},         led, 0);
        check({tag, "_ch_valid"},    ch_valid, 0);
        check({tag, "_scan_done"},   scan_done, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_rd_raw"},      rd_raw, 0);
        check({tag, "_rd_scaled"},   rd_scaled, 0);
    endtask

    initial begin : adc_model
        bit start_prev = 0;
        eoc    = 1'b1;
        result = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            acc[i] = 0; stored[i] = 0; pass_cnt[i] = 0; exp_valid[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (start && !start_prev) begin
                n_starts++;
                if (model_on) begin
                    int ch, v, budget;
                    ch = exp_ch;
                    check("addr_sequence", addr, ch);
                    budget = 0;
                    while (start && budget < 50) begin @(negedge clk); budget++; end
                    check("start_width_bounded", start, 0);
                    if (hang_arm && ch == 2) begin
                        // eoc left high: the controller must give up on this channel.
                        hang_arm     = 0;
                        acc[ch]      = 0;
                        smp_idx      = 0;
                        exp_valid[ch] = 0;
                        if (ch == NUM_CH - 1) exp_wraps++;
                        pass_cnt[ch]++;
                        exp_ch       = (ch + 1) % NUM_CH;
                        timeout_seen = 1;
                    end else begin
                        repeat ($urandom_range(1, 4)) @(negedge clk);
                        eoc = 1'b0;
                        repeat ($urandom_range(4, 20)) @(negedge clk);
                        v = pick_value(ch, pass_cnt[ch], smp_idx);
                        if (drop_arm && ch == 1 && pass_cnt[1] == 1 && smp_idx == AVG_N - 1) begin
                            enable   = 1'b0;
                            drop_arm = 0;
                            repeat (2) @(negedge clk);
                        end
                        result  = 8'(v);
                        eoc     = 1'b1;
                        acc[ch] += v;
                        smp_idx++;
                        if (smp_idx == AVG_N) begin
                            stored[ch]    = acc[ch] / AVG_N;
                            exp_valid[ch] = 1;
                            if (ch == NUM_CH - 1) exp_wraps++;
                            pass_cnt[ch]++;
                            sb_q.push_back('{ch: ch, fin: 1'b1, val: stored[ch]});
                            acc[ch] = 0;
                            smp_idx = 0;
                            exp_ch  = (ch + 1) % NUM_CH;
                        end else begin
                            sb_q.push_back('{ch: ch, fin: 1'b0, val: 0});
                        end
                    end
                end
            end
            start_prev = start;
        end
    end

    initial begin : monitor
        bit   oe_prev = 0;
        rec_t rec;
        forever begin
            @(negedge clk);
            if (reset && oe_prev && !out_en) begin
                if (sb_q.size() == 0) begin
                    check("store_has_expectation", 0, 1);
                end else begin
                    rec = sb_q.pop_front();
                    if (rec.fin) begin
                        @(negedge clk);
                        rd_ch = 3'(rec.ch);
                        #1;
                        check("rd_raw_after_store",    rd_raw, rec.val);
                        check("rd_scaled_after_store", rd_scaled, scaled_of(rec.val));
                        check("led_after_store",       led, rec.val);
                        check("ch_valid_after_store",  ch_valid[rec.ch], 1);
                        check("scan_done_on_wrap",     scan_done, (rec.ch == NUM_CH - 1) ? 1 : 0);
                    end
                end
            end
            oe_prev = out_en;
        end
    end

    initial begin : scan_done_counter
        bit sd_prev = 0;
        forever begin
            @(negedge clk);
            if (reset && scan_done) begin
                sd_cnt++;
                if (sd_prev) check("scan_done_single_cycle", 1, 0);
            end
            sd_prev = scan_done;
        end
    end

    initial begin : adc_clk_monitor
        int run   = 0;
        bit prev  = 0;
        bit first = 1;
        forever begin
            @(negedge clk);
            if (!reset) begin
                run = 0; prev = 0; first = 1;
            end else begin
                run++;
                if (adc_clk != prev) begin
                    if (!first) check("adc_clk_half_period", run, CLK_DIV);
                    first = 0;
                    run   = 0;
                end
                prev = adc_clk;
            end
        end
    end

    initial begin : watchdog
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : main
        int budget, snap;
        reset  = 1'b0;
        enable = 1'b0;
        rd_ch  = 3'd0;
        repeat (3) @(negedge clk);
        check_reset_state("por");

        enable = 1'b1;
        reset  = 1'b1;
        budget = 0;
        while (!start && budget < 200) begin @(negedge clk); budget++; end
        check("first_start_seen", start, 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        check_reset_state("mid_latch");
        @(negedge clk);
        model_on = 1;
        drop_arm = 1;
        reset    = 1'b1;

        // Two passes on fixed data; enable drops during ch1's final WAIT_HI of pass 1.
        budget = 0;
        while (enable && budget < 20000) begin @(negedge clk); budget++; end
        check("enable_dropped_on_ch1", enable, 0);
        repeat (20) @(negedge clk);
        snap = n_starts;
        repeat (100) @(negedge clk);
        check("no_start_while_idle", n_starts, snap);
        check("ch1_valid_after_disable", ch_valid[1], 1);
        check("queue_drained_idle", sb_q.size(), 0);
        rd_ch = 3'd0;
        #1;
        check("ch0_raw",    rd_raw,    (AVG_N == 4) ? 25 : 255);
        check("ch0_scaled", rd_scaled, (AVG_N == 4) ? 98 : 1000);
        rd_ch = 3'd1;
        #1;
        check("ch1_raw",    rd_raw,    128);
        check("ch1_scaled", rd_scaled, 501);
        check("led_last_ch1", led, 128);

        hang_arm = 1;
        enable   = 1'b1;
        budget   = 0;
        while (!timeout_seen && budget < 20000) begin @(negedge clk); budget++; end
        check("hang_reached_ch2", timeout_seen, 1);
        snap   = n_starts;
        budget = 0;
        while (n_starts == snap && budget < TIMEOUT_CYC + 200) begin @(negedge clk); budget++; end
        check("scan_resumed_after_timeout", n_starts > snap, 1);
        check("timeout_err_set", timeout_err, 1);
        check("ch2_invalid_after_timeout", ch_valid[2], 0);

        budget = 0;
        while (pass_cnt[NUM_CH-1] < 4 && budget < 40000) begin @(negedge clk); budget++; end
        check("random_passes_done", pass_cnt[NUM_CH-1] >= 4, 1);
        enable = 1'b0;
        repeat (400) @(negedge clk);

        check("queue_drained_end", sb_q.size(), 0);
        for (int i = 0; i < 8; i++) begin
            rd_ch = 3'(i);
            #1;
            check($sformatf("final_rd_raw_ch%0d", i),    rd_raw,    (i < NUM_CH) ? stored[i] : 0);
            check($sformatf("final_rd_scaled_ch%0d", i), rd_scaled, (i < NUM_CH) ? scaled_of(stored[i]) : 0);
        end
        for (int i = 0; i < NUM_CH; i++)
            check($sformatf("final_ch_valid%0d", i), ch_valid[i], exp_valid[i]);
        check("scan_done_count", sd_cnt, exp_wraps);
        check("timeout_err_sticky", timeout_err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Parametrised multi-channel scanner for the ADC0809-class converter on the board. Drives the converter's address, ALE, START, OE and clock pins, walks channels 0..NUM_CH-1 in a continuous round-robin, and stores a raw 8-bit reading plus a scaled engineering value per channel. It sits between the ADC pins and the LCD/LED display logic, which reads results through a channel-select port. It also adds EOC timeout detection and optional per-channel averaging.

## Interface
- NUM_CH, 8, channels scanned (1..8); addr counts 0..NUM_CH-1
- CLK_DIV, 40, adc_clk half-period in clk cycles (≥1)
- PHASE_CYC, 4, length in clk cycles of the ADDR, LATCH and READ phases (≥1)
- TIMEOUT_CYC, 4096, max clk cycles from LATCH exit to EOC rising
- FULL_SCALE, 1000, scaled value reported for raw 255
- SW, 10, scaled output width; FULL_SCALE < 2^SW
- AVG_LOG2, 2, log2 of samples averaged per channel (used only with ADC_SCAN_AVG_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  scanning enabled while high
- eoc  in  1  converter end-of-conversion (asynchronous)
- result  in  8  converter data bus
- start, ale, out_en, adc_clk  out  1 each  converter controls
- addr  out  3  converter channel address
- rd_ch  in  3  channel to read back
- rd_raw  out  8  stored raw value of rd_ch
- rd_scaled  out  SW  scaled value of rd_ch
- ch_valid  out  NUM_CH  per-channel "holds a good reading"
- scan_done  out  1  one-cycle pulse after channel NUM_CH-1 stored
- timeout_err  out  1  sticky timeout flag
- led  out  8  raw value of most recently stored channel

## Operation
- eoc passes through a 2-flop synchroniser; FSM uses the synchronised value only.
- adc_clk: free-running toggle every CLK_DIV clk cycles, independent of FSM.
- FSM states: IDLE, ADDR, LATCH, WAIT_LO, WAIT_HI, READ, STORE.
  - IDLE: all strobes 0; enable=1 -> ADDR.
  - ADDR: addr=current channel, PHASE_CYC cycles -> LATCH.
  - LATCH: ale=1, start=1 for PHASE_CYC cycles -> WAIT_LO.
  - WAIT_LO: wait synced eoc=0 -> WAIT_HI.
  - WAIT_HI: wait synced eoc=1 -> READ.
  - READ: out_en=1 for PHASE_CYC cycles; result captured on last cycle -> STORE.
  - STORE (1 cycle): write channel register, set ch_valid[ch], update led; advance channel (wrap NUM_CH-1 -> 0, pulse scan_done on wrap); -> ADDR if enable else IDLE.
- Timeout: timer starts on LATCH exit; reaching TIMEOUT_CYC in WAIT_LO/WAIT_HI sets timeout_err, clears ch_valid[ch], leaves stored value unchanged, advances channel as STORE does (scan_done still pulses on wrap).
- enable falling mid-conversion: current conversion completes through STORE, then IDLE.
- rd_scaled = floor(rd_raw × FULL_SCALE / 255), combinational from stored raw, computed at ≥ (8+SW) bits, truncated to SW.
- rd_ch ≥ NUM_CH: rd_raw=0, rd_scaled=0.

## Timing
- Reset (asynchronous, immediate, including mid-conversion): start=ale=out_en=adc_clk=0, addr=0, led=0, ch_valid=0, scan_done=0, timeout_err=0, all channel registers 0, FSM=IDLE, channel=0.
- Minimum per-conversion latency: 3×PHASE_CYC + 1 STORE + eoc response + 2-cycle sync per eoc edge.
- rd_raw/rd_scaled reflect a STORE on the following clk edge.
- timeout_err clears only on reset.

## Configuration
- ADC_SCAN_AVG_EN defined: each channel is converted 2^AVG_LOG2 consecutive times; samples summed into a (8+AVG_LOG2)-bit accumulator; STORE writes sum>>AVG_LOG2 after the last sample only; a timeout on any sample discards the sum and advances the channel. scan_done/led/ch_valid update only on final store.
- Undefined: one conversion per channel; AVG_LOG2 ignored; no accumulator logic.

## Test plan
- Reset mid-LATCH with enable=1 -> all outputs at reset values same cycle; after release first addr=0.
- NUM_CH=4, model returns result=8'hFF on ch0, 8'h80 on ch1 -> rd_ch=0: rd_raw=255, rd_scaled=1000; rd_ch=1: rd_raw=128, rd_scaled=501; scan_done pulses once per 4 stores; addr sequence 0,1,2,3,0.
- eoc held high forever on ch2 -> timeout_err=1 after TIMEOUT_CYC, ch_valid[2]=0, scan continues to ch3.
- enable dropped during WAIT_HI on ch1 -> ch1 stored, ch_valid[1]=1, FSM in IDLE, no further start pulse.
- ADC_SCAN_AVG_EN, AVG_LOG2=2, ch0 samples 10,20,30,41 -> rd_raw=25, single STORE, led=25.
